// File: rtl/mem_stage_pkg.sv
// Shared CPU widths and pipeline-register layouts for the memory stage.
package mem_stage_pkg;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned REG_W          = 5;
  localparam int unsigned DEPTH_LOG2_DEF = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regn_t;

  typedef struct packed {
    word_t alu;
    word_t b;
    regn_t rn;
    logic  wreg;
    logic  m2reg;
    logic  wmem;
    logic  valid;
  } exmem_t;

  typedef struct packed {
    word_t alu;
    word_t mo;
    regn_t rn;
    logic  wreg;
    logic  m2reg;
  } memwb_t;
endpackage

// File: rtl/mem_stage_if.sv
// Execute-side inputs and forwarding/write-back outputs of the memory stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  word_t ealu;
  word_t eb;
  regn_t ern;
  logic  ewreg;
  logic  em2reg;
  logic  ewmem;
  logic  stall;
  logic  flush;

  word_t malu;
  regn_t mrn;
  logic  mwreg;
  logic  mm2reg;
  regn_t wrn;
  logic  wwreg;
  word_t wdi;
  word_t wmo;
  word_t walu;
  logic  wm2reg;

  modport master (
    output ealu, eb, ern, ewreg, em2reg, ewmem, stall, flush,
    input  malu, mrn, mwreg, mm2reg, wrn, wwreg, wdi, wmo, walu, wm2reg
  );

  modport slave (
    input  ealu, eb, ern, ewreg, em2reg, ewmem, stall, flush,
    output malu, mrn, mwreg, mm2reg, wrn, wwreg, wdi, wmo, walu, wm2reg
  );
endinterface

// File: rtl/mem_stage_data_ram.sv
// Single-port data RAM: asynchronous read, synchronous write, no reset.
module data_ram
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  word_t                 i_di,
  output word_t                 o_do
);
  word_t r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_di;
  end

  assign o_do = r_mem[i_addr];
endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data RAM access, MEM/WB register and write-back mux.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input logic        clk,
  input logic        clrn,
  mem_stage_if.slave bus
);
  exmem_t                r_em;
  memwb_t                r_mw;
  word_t                 w_ram_do;
  logic                  w_ram_we;
  logic [DEPTH_LOG2-1:0] w_ram_addr;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_em <= '0;
    end else if (!bus.stall) begin
      if (bus.flush) begin
        r_em <= '0;
      end else begin
        r_em <= '{alu: bus.ealu, b: bus.eb, rn: bus.ern, wreg: bus.ewreg,
                  m2reg: bus.em2reg, wmem: bus.ewmem, valid: 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_mw <= '0;
    end else if (!bus.stall) begin
      r_mw <= '{alu: r_em.alu, mo: w_ram_do, rn: r_em.rn,
                wreg: r_em.wreg, m2reg: r_em.m2reg};
    end
  end

  // Word index ignores byte offset and upper bits, so addresses wrap.
  assign w_ram_addr = r_em.alu[DEPTH_LOG2+1:2];
  assign w_ram_we   = r_em.wmem & r_em.valid & ~bus.stall;

  data_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_di   (r_em.b),
    .o_do   (w_ram_do)
  );

  assign bus.malu   = r_em.alu;
  assign bus.mrn    = r_em.rn;
  assign bus.mwreg  = r_em.wreg;
  assign bus.mm2reg = r_em.m2reg;
  assign bus.walu   = r_mw.alu;
  assign bus.wmo    = r_mw.mo;
  assign bus.wrn    = r_mw.rn;
  assign bus.wwreg  = r_mw.wreg;
  assign bus.wm2reg = r_mw.m2reg;
  assign bus.wdi    = r_mw.m2reg ? r_mw.mo : r_mw.alu;
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
  logic clk;
  logic clrn;
  int   n_pass;
  int   n_total;
  int   wr1_cnt;

  mem_stage_if bus ();

  mem_stage #(.DEPTH_LOG2(5)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.w_ram_we && dut.w_ram_addr == 5'd1) wr1_cnt = wr1_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                       input logic wreg, input logic m2reg, input logic wmem);
    bus.ealu   = alu;
    bus.eb     = b;
    bus.ern    = rn;
    bus.ewreg  = wreg;
    bus.em2reg = m2reg;
    bus.ewmem  = wmem;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      bus.stall = 1'($urandom);
      bus.flush = 1'($urandom);
      step();
    end
    n_total++;
    if ({bus.malu, bus.mrn, bus.mwreg, bus.mm2reg} !== 39'h0)
      $display("FAIL reset_m: got malu=%h mrn=%0d mwreg=%b mm2reg=%b want 0",
               bus.malu, bus.mrn, bus.mwreg, bus.mm2reg);
    else n_pass++;
    n_total++;
    if ({bus.walu, bus.wmo, bus.wdi, bus.wrn, bus.wwreg, bus.wm2reg} !== 103'h0)
      $display("FAIL reset_w: got walu=%h wmo=%h wdi=%h wrn=%0d wwreg=%b wm2reg=%b want 0",
               bus.walu, bus.wmo, bus.wdi, bus.wrn, bus.wwreg, bus.wm2reg);
    else n_pass++;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    clrn = 1'b1;
    step();
    n_total++;
    if (bus.malu !== 32'h10 || bus.mwreg !== 1'b1 || bus.mrn !== 5'd3)
      $display("FAIL first_m: got malu=%h mwreg=%b mrn=%0d want 10/1/3", bus.malu, bus.mwreg, bus.mrn);
    else n_pass++;
    nop();
    step();
    n_total++;
    if (bus.wdi !== 32'h10 || bus.wrn !== 5'd3 || bus.wwreg !== 1'b1)
      $display("FAIL first_wb: got wdi=%h wrn=%0d wwreg=%b want 10/3/1", bus.wdi, bus.wrn, bus.wwreg);
    else n_pass++;
  endtask

  task automatic test_store_load();
    drive(32'h08, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1);
    step();
    drive(32'h08, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    n_total++;
    if (bus.mm2reg !== 1'b1) $display("FAIL load_mm2reg: got %b want 1", bus.mm2reg);
    else n_pass++;
    nop();
    step();
    n_total++;
    if (bus.wmo !== 32'hDEADBEEF || bus.wdi !== 32'hDEADBEEF)
      $display("FAIL store_load: got wmo=%h wdi=%h want deadbeef", bus.wmo, bus.wdi);
    else n_pass++;
    n_total++;
    if (bus.wrn !== 5'd5 || bus.wm2reg !== 1'b1 || bus.wwreg !== 1'b1)
      $display("FAIL load_ctl: got wrn=%0d wm2reg=%b wwreg=%b want 5/1/1", bus.wrn, bus.wm2reg, bus.wwreg);
    else n_pass++;
  endtask

  task automatic test_wrap();
    drive(32'h0000_0081, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1);
    step();
    drive(32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
    step();
    nop();
    step();
    n_total++;
    if (bus.wdi !== 32'h12345678) $display("FAIL wrap: got wdi=%h want 12345678", bus.wdi);
    else n_pass++;
  endtask

  task automatic test_stall();
    drive(32'h04, 32'h11111111, 5'd7, 1'b0, 1'b0, 1'b1);
    step();
    drive(32'h04, 32'hA5A5A5A5, 5'd8, 1'b0, 1'b0, 1'b1);
    step();
    wr1_cnt = 0;
    bus.stall = 1'b1;
    drive(32'h44, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    n_total++;
    if (bus.malu !== 32'h04 || bus.mrn !== 5'd8 || bus.mwreg !== 1'b0 || bus.mm2reg !== 1'b0)
      $display("FAIL stall_m: got malu=%h mrn=%0d want 04/8", bus.malu, bus.mrn);
    else n_pass++;
    n_total++;
    if (bus.walu !== 32'h04 || bus.wrn !== 5'd7 || bus.wwreg !== 1'b0)
      $display("FAIL stall_w: got walu=%h wrn=%0d wwreg=%b want 04/7/0", bus.walu, bus.wrn, bus.wwreg);
    else n_pass++;
    n_total++;
    if (dut.u_ram.r_mem[1] !== 32'h11111111)
      $display("FAIL stall_word1: got %h want 11111111", dut.u_ram.r_mem[1]);
    else n_pass++;
    bus.stall = 1'b0;
    nop();
    step();
    step();
    n_total++;
    if (dut.u_ram.r_mem[1] !== 32'hA5A5A5A5 || wr1_cnt !== 1)
      $display("FAIL stall_release: got word1=%h writes=%0d want a5a5a5a5/1", dut.u_ram.r_mem[1], wr1_cnt);
    else n_pass++;
  endtask

  task automatic test_flush();
    drive(32'h0C, 32'h33333333, 5'd0, 1'b0, 1'b0, 1'b1);
    step();
    nop();
    step();
    drive(32'h0C, 32'h1, 5'd10, 1'b1, 1'b0, 1'b1);
    bus.flush = 1'b1;
    step();
    n_total++;
    if (bus.mwreg !== 1'b0 || bus.malu !== 32'h0)
      $display("FAIL flush_m: got mwreg=%b malu=%h want 0/0", bus.mwreg, bus.malu);
    else n_pass++;
    bus.flush = 1'b0;
    nop();
    step();
    n_total++;
    if (bus.wwreg !== 1'b0 || dut.u_ram.r_mem[3] !== 32'h33333333)
      $display("FAIL flush_w: got wwreg=%b word3=%h want 0/33333333", bus.wwreg, dut.u_ram.r_mem[3]);
    else n_pass++;
    drive(32'h20, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h3C, 32'h5, 5'd2, 1'b0, 1'b1, 1'b1);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    n_total++;
    if (bus.malu !== 32'h20 || bus.mwreg !== 1'b1 || bus.mrn !== 5'd9)
      $display("FAIL flush_stall: got malu=%h mwreg=%b mrn=%0d want 20/1/9", bus.malu, bus.mwreg, bus.mrn);
    else n_pass++;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    nop();
    step();
  endtask

  task automatic test_reset_mid();
    drive(32'h10, 32'h44444444, 5'd0, 1'b0, 1'b0, 1'b1);
    step();
    nop();
    step();
    drive(32'h10, 32'h00000BAD, 5'd4, 1'b1, 1'b0, 1'b1);
    step();
    nop();
    #2 clrn = 1'b0;
    #1;
    n_total++;
    if (bus.malu !== 32'h0 || bus.mwreg !== 1'b0 || bus.wdi !== 32'h0 || bus.walu !== 32'h0)
      $display("FAIL reset_async: got malu=%h mwreg=%b wdi=%h walu=%h want 0",
               bus.malu, bus.mwreg, bus.wdi, bus.walu);
    else n_pass++;
    #1 clrn = 1'b1;
    step();
    step();
    n_total++;
    if (dut.u_ram.r_mem[4] !== 32'h44444444)
      $display("FAIL reset_discard: got word4=%h want 44444444", dut.u_ram.r_mem[4]);
    else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    wr1_cnt   = 0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    nop();
    test_reset();
    test_store_load();
    test_wrap();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage CPU, sitting directly downstream of the execute stage. It registers the execute-stage result, ALU output plus store data and control, in an EX/MEM pipeline register. It performs the data-memory access against an internal 32-word RAM and registers the outcome in a MEM/WB pipeline register for write-back. It also exports EX/MEM fields to the decode-stage forwarding logic.

## Interface
Parameters:
- `DEPTH_LOG2`, 5: data RAM depth is 2^DEPTH_LOG2 words, 32 bits each.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `clrn`, in, 1: asynchronous reset, active-low.
- `ealu`, in, 32: ALU result from execute; the memory byte address for loads and stores.
- `eb`, in, 32: register operand b; the store data.
- `ern`, in, 5: destination register number.
- `ewreg`, in, 1: instruction writes the register file.
- `em2reg`, in, 1: write-back value comes from memory (load).
- `ewmem`, in, 1: instruction writes memory (store).
- `stall`, in, 1: hold both pipeline registers and suppress the RAM write.
- `flush`, in, 1: replace the instruction entering EX/MEM with a bubble.
- `malu`, out, 32: EX/MEM ALU result, for forwarding.
- `mrn`, out, 5: EX/MEM destination register.
- `mwreg`, out, 1: EX/MEM write-enable, for forwarding.
- `mm2reg`, out, 1: EX/MEM load flag, for load-use hazard detection.
- `wrn`, out, 5: MEM/WB destination register.
- `wwreg`, out, 1: MEM/WB register-file write-enable.
- `wdi`, out, 32: write-back data; `wmo` when `wm2reg`=1, else `walu`.
- `wmo`, out, 32: MEM/WB registered memory read data.
- `walu`, out, 32: MEM/WB registered ALU result.
- `wm2reg`, out, 1: MEM/WB load flag.

## Operation
- RAM word index is `malu[DEPTH_LOG2+1:2]`.
  - `malu[1:0]` and the upper address bits are ignored; there is no alignment fault and no bound check, so addresses wrap modulo 2^DEPTH_LOG2 words.
- RAM read is asynchronous (combinational from `malu`).
- RAM write is synchronous: it happens at the rising edge when `mwmem`=1, `mvalid`=1 and `stall`=0, with data `mb`.
- EX/MEM register contents: `malu`, `mb`, `mrn`, `mwreg`, `mm2reg`, `mwmem`, plus an internal `mvalid`.
- MEM/WB register contents: `walu`, `wmo`, `wrn`, `wwreg`, `wm2reg`.
- Edge behaviour, `stall`=0, `flush`=0: EX/MEM loads the execute inputs with `mvalid`=1, and MEM/WB loads the current EX/MEM values with `wmo` = RAM read data.
- `flush`=1 with `stall`=0: EX/MEM loads a bubble (`mwreg`=`mm2reg`=`mwmem`=`mvalid`=0; data fields are don't-care, implemented as zero). MEM/WB advances normally.
- `stall`=1: both registers hold and no RAM write occurs. `stall` has priority over `flush`.
- A bubble in EX/MEM propagates to MEM/WB as `wwreg`=0, `wm2reg`=0.
- Reset (`clrn`=0), asynchronous:
  - All pipeline register fields go to 0, so every output reads 0 (including `wdi`).
  - RAM contents are not reset.
  - A store pending in EX/MEM at the moment of reset is discarded and never written.

## Timing
- Execute inputs are sampled at edge N, visible on the `m*` outputs after edge N.
- A store writes the RAM at edge N+1.
- A load result appears on `wmo`/`wdi` after edge N+1. Latency from execute to write-back outputs is 2 edges.
- Store at edge N+1 followed by a load of the same word in EX/MEM during cycle N+1: the load reads the new value, so no extra forwarding is needed.
- Store and load of the same word in the same cycle cannot occur (one instruction per stage).
- Forwarding outputs `malu`/`mrn`/`mwreg`/`mm2reg` are pure register outputs with no combinational path from inputs.
- `wdi` is a combinational mux of MEM/WB registers only.

## Structure
- Shared CPU package or header holds: data width 32, register-number width 5, and default `DEPTH_LOG2`.
- One sub-module: `data_ram`. It is a single-port RAM with async read and sync write, with ports `clk`, `we`, `addr`, `di`, `do`, and no reset.
- Pipeline registers and the `wdi` mux stay in `mem_stage`.

## Test plan
- Reset: hold `clrn`=0 with random inputs, then check all outputs = 0. Release `clrn`, drive `ealu`=0x10, `ewreg`=1, `ern`=3, and check after 2 edges that `wdi`=0x10, `wrn`=3, `wwreg`=1.
- Store then load: store `eb`=0xDEADBEEF at `ealu`=0x08, then next cycle load from 0x08 (`em2reg`=1, `ern`=5). Check `wmo`=`wdi`=0xDEADBEEF and `wrn`=5 two edges after the load enters.
- Wrap and alignment: store 0x12345678 at `ealu`=0x0000_0081, then load from 0x0000_0000. Check `wdi`=0x12345678 (word 0 after wrap, low bits ignored).
- Stall: assert `stall` for 3 cycles while a store of 0xA5A5A5A5 to 0x04 sits in EX/MEM. Check `m*` and `w*` hold and word 1 is unchanged. After release, check word 1 = 0xA5A5A5A5 written exactly once.
- Flush and priority:
  - `flush`=1 with a store of 0x1 to 0x0C: check word 3 is unchanged, `mwreg`=0, and then `wwreg`=0.
  - `flush`=1 together with `stall`=1: check EX/MEM holds its prior valid instruction.
- Reset mid-operation: pulse `clrn` low between edges while a store to 0x10 is in EX/MEM. Check word 4 keeps its old value and outputs go to 0 immediately, without waiting for a clock edge.
